// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : alu_pkg                                                          |
// | Brief   : Opcode encodings, datapath widths and opcode helpers shared by   |
// |           the issue stage and the 8-bit ALU.                               |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package alu_pkg;

    localparam int DATA_W  = 8;
    localparam int NREG    = 8;
    localparam int REG_AW  = $clog2(NREG);
    localparam int OP_W    = 3;
    localparam int INSTR_W = OP_W + 2 * REG_AW;

    localparam logic [OP_W-1:0] OP_AND = 3'b000;
    localparam logic [OP_W-1:0] OP_ADD = 3'b001;
    localparam logic [OP_W-1:0] OP_SLL = 3'b010;
    localparam logic [OP_W-1:0] OP_SRL = 3'b011;
    localparam logic [OP_W-1:0] OP_SUB = 3'b100;
    localparam logic [OP_W-1:0] OP_SLT = 3'b101;
    localparam logic [OP_W-1:0] OP_ABS = 3'b110;
    localparam logic [OP_W-1:0] OP_SEQ = 3'b111;

    // Unary ops ignore rt, so a busy rt must not hold them back.
    function automatic logic op_uses_rt(input logic [OP_W-1:0] op);
        return (op != OP_SRL) && (op != OP_ABS);
    endfunction

    // Compare ops only produce a flag and never write rd.
    function automatic logic op_writes_rd(input logic [OP_W-1:0] op);
        return (op != OP_SLT) && (op != OP_SEQ);
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/regfile_2r1w.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : regfile_2r1w                                                     |
// | Brief   : Register file with two asynchronous read ports that forward a    |
// |           same-cycle write, one synchronous write port, sync reset.        |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module regfile_2r1w #(
    parameter int DATA_W = 8,
    parameter int NREG   = 8,
    parameter int AW     = $clog2(NREG)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [AW-1:0]     raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o
);

    logic [DATA_W-1:0] r_mem [NREG];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we_i) begin
            r_mem[waddr_i] <= wdata_i;
        end
    end

    // Forwarding lets an operand be consumed in the same cycle it is written back.
    always_comb begin
        rdata_a_o = r_mem[raddr_a_i];
        if (we_i && (waddr_i == raddr_a_i)) begin
            rdata_a_o = wdata_i;
        end
    end

    always_comb begin
        rdata_b_o = r_mem[raddr_b_i];
        if (we_i && (waddr_i == raddr_b_i)) begin
            rdata_b_o = wdata_i;
        end
    end

endmodule : regfile_2r1w
`default_nettype wire

// File: rtl/decode_regread.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : decode_regread                                                   |
// | Brief   : Issue stage ahead of the ALU: decode, operand read, busy-bit     |
// |           scoreboard stall and a single output register toward the ALU.    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module decode_regread #(
    parameter  int DATA_W  = 8,
    parameter  int NREG    = 8,
    parameter  int INSTR_W = 9,
    localparam int AW      = $clog2(NREG),
    localparam int OPW     = INSTR_W - 2 * AW
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic               instr_valid_i,
    output logic               instr_ready_o,
    input  logic               wb_en_i,
    input  logic [AW-1:0]      wb_addr_i,
    input  logic [DATA_W-1:0]  wb_data_i,
    output logic               valid_o,
    output logic [OPW-1:0]     opcode_o,
    output logic [DATA_W-1:0]  rs_o,
    output logic [DATA_W-1:0]  rt_o,
    output logic [AW-1:0]      rd_addr_o,
    output logic               wr_req_o
);

    import alu_pkg::*;

    logic [OPW-1:0]    w_opcode;
    logic [AW-1:0]     w_rs_addr;
    logic [AW-1:0]     w_rt_addr;
    logic [DATA_W-1:0] w_rs_data;
    logic [DATA_W-1:0] w_rt_data;
    logic              w_uses_rt;
    logic              w_writes_rd;
    logic [NREG-1:0]   w_wb_clear;
    logic [NREG-1:0]   w_issue_set;
    logic [NREG-1:0]   w_busy_live;
    logic              w_stall;
    logic              w_accept;

    logic [NREG-1:0]   r_busy;
    logic              r_valid;
    logic [OPW-1:0]    r_opcode;
    logic [DATA_W-1:0] r_rs;
    logic [DATA_W-1:0] r_rt;
    logic [AW-1:0]     r_rd_addr;
    logic              r_wr_req;

    // rs and rd share a field, so rd needs no separate decode.
    assign w_opcode    = instr_i[INSTR_W-1 -: OPW];
    assign w_rs_addr   = instr_i[2*AW-1 -: AW];
    assign w_rt_addr   = instr_i[AW-1:0];
    assign w_uses_rt   = op_uses_rt(w_opcode);
    assign w_writes_rd = op_writes_rd(w_opcode);

    regfile_2r1w #(
        .DATA_W (DATA_W),
        .NREG   (NREG),
        .AW     (AW)
    ) u_regfile (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .we_i      (wb_en_i),
        .waddr_i   (wb_addr_i),
        .wdata_i   (wb_data_i),
        .raddr_a_i (w_rs_addr),
        .rdata_a_o (w_rs_data),
        .raddr_b_i (w_rt_addr),
        .rdata_b_o (w_rt_data)
    );

    always_comb begin
        w_wb_clear = '0;
        if (wb_en_i) begin
            w_wb_clear[wb_addr_i] = 1'b1;
        end
    end

    // Busy view after this cycle's writeback; the forwarded value makes that safe.
    assign w_busy_live   = r_busy & ~w_wb_clear;
    assign w_stall       = w_busy_live[w_rs_addr] | (w_uses_rt & w_busy_live[w_rt_addr]);
    assign instr_ready_o = ~w_stall;
    assign w_accept      = instr_valid_i & instr_ready_o;

    always_comb begin
        w_issue_set = '0;
        if (w_accept && w_writes_rd) begin
            w_issue_set[w_rs_addr] = 1'b1;
        end
    end

    // OR-ing the set after the clear makes a new producer win over a retiring one.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_live | w_issue_set;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid   <= 1'b0;
            r_opcode  <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_rd_addr <= '0;
            r_wr_req  <= 1'b0;
        end else begin
            r_valid <= w_accept;
            if (w_accept) begin
                r_opcode  <= w_opcode;
                r_rs      <= w_rs_data;
                r_rt      <= w_rt_data;
                r_rd_addr <= w_rs_addr;
                r_wr_req  <= w_writes_rd;
            end
        end
    end

    assign valid_o   = r_valid;
    assign opcode_o  = r_opcode;
    assign rs_o      = r_rs;
    assign rt_o      = r_rt;
    assign rd_addr_o = r_rd_addr;
    assign wr_req_o  = r_wr_req;

endmodule : decode_regread
`default_nettype wire

// File: tb/tb_decode_regread.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_decode_regread                                                |
// | Brief   : Directed self-checking bench for the decode/register-read stage. |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_decode_regread;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [8:0] instr_i;
    logic       instr_valid_i;
    logic       instr_ready_o;
    logic       wb_en_i;
    logic [2:0] wb_addr_i;
    logic [7:0] wb_data_i;
    logic       valid_o;
    logic [2:0] opcode_o;
    logic [7:0] rs_o;
    logic [7:0] rt_o;
    logic [2:0] rd_addr_o;
    logic       wr_req_o;

    int checks = 0;
    int errors = 0;

    decode_regread dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .instr_i       (instr_i),
        .instr_valid_i (instr_valid_i),
        .instr_ready_o (instr_ready_o),
        .wb_en_i       (wb_en_i),
        .wb_addr_i     (wb_addr_i),
        .wb_data_i     (wb_data_i),
        .valid_o       (valid_o),
        .opcode_o      (opcode_o),
        .rs_o          (rs_o),
        .rt_o          (rt_o),
        .rd_addr_o     (rd_addr_o),
        .wr_req_o      (wr_req_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exhausted, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        instr_valid_i = 1'b0;
        wb_en_i       = 1'b0;
    endtask

    task automatic wb(input logic [2:0] addr, input logic [7:0] data);
        instr_valid_i = 1'b0;
        wb_en_i   = 1'b1;
        wb_addr_i = addr;
        wb_data_i = data;
        tick();
        wb_en_i   = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        instr_i = 9'd0;
        idle();
        wb_addr_i = 3'd0;
        wb_data_i = 8'd0;
        tick();
        tick();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0h expected 0", valid_o); end
        checks++; if (opcode_o !== 3'd0) begin errors++; $display("FAIL reset_opcode: got %0h expected 0", opcode_o); end
        checks++; if (rs_o !== 8'd0) begin errors++; $display("FAIL reset_rs: got %0h expected 0", rs_o); end
        checks++; if (rt_o !== 8'd0) begin errors++; $display("FAIL reset_rt: got %0h expected 0", rt_o); end
        checks++; if (rd_addr_o !== 3'd0) begin errors++; $display("FAIL reset_rd: got %0h expected 0", rd_addr_o); end
        checks++; if (wr_req_o !== 1'b0) begin errors++; $display("FAIL reset_wr_req: got %0h expected 0", wr_req_o); end
        checks++; if (instr_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0h expected 1", instr_ready_o); end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_issue();
        wb(3'd1, 8'h05);
        wb(3'd7, 8'h03);
        instr_i = 9'b001_001_111;
        instr_valid_i = 1'b1;
        #1;
        checks++; if (instr_ready_o !== 1'b1) begin errors++; $display("FAIL issue_ready: got %0h expected 1", instr_ready_o); end
        tick();
        instr_valid_i = 1'b0;
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL issue_valid: got %0h expected 1", valid_o); end
        checks++; if (opcode_o !== 3'b001) begin errors++; $display("FAIL issue_opcode: got %0h expected 1", opcode_o); end
        checks++; if (rs_o !== 8'h05) begin errors++; $display("FAIL issue_rs: got %0h expected 05", rs_o); end
        checks++; if (rt_o !== 8'h03) begin errors++; $display("FAIL issue_rt: got %0h expected 03", rt_o); end
        checks++; if (rd_addr_o !== 3'd1) begin errors++; $display("FAIL issue_rd: got %0h expected 1", rd_addr_o); end
        checks++; if (wr_req_o !== 1'b1) begin errors++; $display("FAIL issue_wr_req: got %0h expected 1", wr_req_o); end
        // Retire the add so r1 is free again.
        wb(3'd1, 8'h05);
    endtask

    task automatic test_raw_stall();
        instr_i = 9'b001_001_111;
        instr_valid_i = 1'b1;
        tick();
        #1;
        checks++; if (instr_ready_o !== 1'b0) begin errors++; $display("FAIL raw_stall_ready: got %0h expected 0", instr_ready_o); end
        tick();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL raw_stall_bubble: got %0h expected 0", valid_o); end
        checks++; if (instr_ready_o !== 1'b0) begin errors++; $display("FAIL raw_stall_hold: got %0h expected 0", instr_ready_o); end
        wb_en_i = 1'b1;
        wb_addr_i = 3'd1;
        wb_data_i = 8'h08;
        #1;
        checks++; if (instr_ready_o !== 1'b1) begin errors++; $display("FAIL raw_wb_ready: got %0h expected 1", instr_ready_o); end
        tick();
        idle();
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL raw_issue_valid: got %0h expected 1", valid_o); end
        checks++; if (rs_o !== 8'h08) begin errors++; $display("FAIL raw_fwd_rs: got %0h expected 08", rs_o); end
        checks++; if (rt_o !== 8'h03) begin errors++; $display("FAIL raw_rt: got %0h expected 03", rt_o); end
        wb(3'd1, 8'h08);
    endtask

    task automatic test_nonwrite();
        instr_i = 9'b111_011_111;
        instr_valid_i = 1'b1;
        tick();
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL seq_valid: got %0h expected 1", valid_o); end
        checks++; if (opcode_o !== 3'b111) begin errors++; $display("FAIL seq_opcode: got %0h expected 7", opcode_o); end
        checks++; if (wr_req_o !== 1'b0) begin errors++; $display("FAIL seq_wr_req: got %0h expected 0", wr_req_o); end
        checks++; if (rd_addr_o !== 3'd3) begin errors++; $display("FAIL seq_rd: got %0h expected 3", rd_addr_o); end
        instr_i = 9'b001_011_011;
        #1;
        checks++; if (instr_ready_o !== 1'b1) begin errors++; $display("FAIL seq_no_busy: got %0h expected 1", instr_ready_o); end
        tick();
        instr_valid_i = 1'b0;
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL r3_reader_valid: got %0h expected 1", valid_o); end
        checks++; if (wr_req_o !== 1'b1) begin errors++; $display("FAIL r3_reader_wr_req: got %0h expected 1", wr_req_o); end
        // r3 is now busy: only ops that actually read rt may stall on it.
        instr_i = 9'b011_000_011;
        #1;
        checks++; if (instr_ready_o !== 1'b1) begin errors++; $display("FAIL srl_ignores_rt: got %0h expected 1", instr_ready_o); end
        instr_i = 9'b110_000_011;
        #1;
        checks++; if (instr_ready_o !== 1'b1) begin errors++; $display("FAIL abs_ignores_rt: got %0h expected 1", instr_ready_o); end
        instr_i = 9'b000_000_011;
        #1;
        checks++; if (instr_ready_o !== 1'b0) begin errors++; $display("FAIL and_rt_stall: got %0h expected 0", instr_ready_o); end
        instr_i = 9'b101_000_011;
        #1;
        checks++; if (instr_ready_o !== 1'b0) begin errors++; $display("FAIL slt_rt_stall: got %0h expected 0", instr_ready_o); end
        wb(3'd3, 8'h33);
        // Write-through on rt while issuing.
        instr_i = 9'b000_110_101;
        instr_valid_i = 1'b1;
        wb_en_i = 1'b1;
        wb_addr_i = 3'd5;
        wb_data_i = 8'hAA;
        tick();
        idle();
        checks++; if (rt_o !== 8'hAA) begin errors++; $display("FAIL wt_rt: got %0h expected aa", rt_o); end
        checks++; if (rs_o !== 8'h00) begin errors++; $display("FAIL wt_rs: got %0h expected 00", rs_o); end
        wb(3'd6, 8'h66);
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL idle_valid: got %0h expected 0", valid_o); end
        checks++; if (rt_o !== 8'hAA) begin errors++; $display("FAIL idle_hold_rt: got %0h expected aa", rt_o); end
        checks++; if (rd_addr_o !== 3'd6) begin errors++; $display("FAIL idle_hold_rd: got %0h expected 6", rd_addr_o); end
    endtask

    task automatic test_set_wins();
        instr_i = 9'b001_100_000;
        instr_valid_i = 1'b1;
        tick();
        wb_en_i = 1'b1;
        wb_addr_i = 3'd4;
        wb_data_i = 8'h44;
        #1;
        checks++; if (instr_ready_o !== 1'b1) begin errors++; $display("FAIL setwin_ready: got %0h expected 1", instr_ready_o); end
        tick();
        idle();
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL setwin_valid: got %0h expected 1", valid_o); end
        checks++; if (rs_o !== 8'h44) begin errors++; $display("FAIL setwin_rs: got %0h expected 44", rs_o); end
        instr_i = 9'b000_000_100;
        #1;
        checks++; if (instr_ready_o !== 1'b0) begin errors++; $display("FAIL setwin_busy: got %0h expected 0", instr_ready_o); end
        tick();
        checks++; if (instr_ready_o !== 1'b0) begin errors++; $display("FAIL setwin_busy_hold: got %0h expected 0", instr_ready_o); end
    endtask

    task automatic test_mid_reset();
        instr_i = 9'b001_001_111;
        instr_valid_i = 1'b1;
        tick();
        #1;
        checks++; if (instr_ready_o !== 1'b0) begin errors++; $display("FAIL midrst_stall: got %0h expected 0", instr_ready_o); end
        rst_i = 1'b1;
        tick();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %0h expected 0", valid_o); end
        checks++; if (rs_o !== 8'h00) begin errors++; $display("FAIL midrst_rs: got %0h expected 00", rs_o); end
        checks++; if (opcode_o !== 3'd0) begin errors++; $display("FAIL midrst_opcode: got %0h expected 0", opcode_o); end
        rst_i = 1'b0;
        #1;
        checks++; if (instr_ready_o !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %0h expected 1", instr_ready_o); end
        tick();
        instr_valid_i = 1'b0;
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL postrst_valid: got %0h expected 1", valid_o); end
        checks++; if (rs_o !== 8'h00) begin errors++; $display("FAIL postrst_rs: got %0h expected 00", rs_o); end
        checks++; if (rt_o !== 8'h00) begin errors++; $display("FAIL postrst_rt: got %0h expected 00", rt_o); end
        checks++; if (opcode_o !== 3'b001) begin errors++; $display("FAIL postrst_opcode: got %0h expected 1", opcode_o); end
    endtask

    initial begin
        test_reset();
        test_issue();
        test_raw_stall();
        test_nonwrite();
        test_set_wins();
        test_mid_reset();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_decode_regread
`default_nettype wire
